axi_slv_rd_sched: RTL

Read-side scheduler for the AXI slave responder bench model. It accepts AR requests into a fixed outstanding table and arbitrates R-channel bursts between them round-robin, with optional beat-level interleaving across IDs. Same-ID ordering is always preserved. It generates R beats with LFSR data so the master under test sees legal, reorderable read traffic.

---
 rtl/axi_slv_rd_sched.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/axi_slv_rd_sched.sv
// AXI slave read scheduler: AR outstanding table, round-robin R bursts, LFSR read data.
module axi_slv_rd_sched #(
  parameter int unsigned AXI_ID_W   = 4,
  parameter int unsigned AXI_DATA_W = 32,
  parameter int unsigned OSTD_NUM   = 4,
  parameter bit          INTERLEAVE = 1'b0,
  parameter logic [31:0] LFSR_SEED  = 32'h0000_0001
) (
  input  logic                        aclk,
  input  logic                        srst,
  input  logic                        in_arvalid,
  output logic                        out_arready,
  input  logic [AXI_ID_W-1:0]         in_arid,
  input  logic [3:0]                  in_arlen,
  output logic                        out_rvalid,
  input  logic                        in_rready,
  output logic [AXI_ID_W-1:0]         out_rid,
  output logic [AXI_DATA_W-1:0]       out_rdata,
  output logic [1:0]                  out_rresp,
  output logic                        out_rlast,
  output logic [$clog2(OSTD_NUM):0]   out_ostd_cnt
);

  localparam int unsigned IDX_W     = $clog2(OSTD_NUM);
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t              r_state, w_state_nxt;
  logic [OSTD_NUM-1:0] r_vld, r_tail, r_dep_vld;
  logic [AXI_ID_W-1:0] r_id      [OSTD_NUM];
  logic [3:0]          r_len     [OSTD_NUM];
  logic [3:0]          r_beat    [OSTD_NUM];
  logic [IDX_W-1:0]    r_dep_idx [OSTD_NUM];
  logic [IDX_W-1:0]    r_grant, r_rr_ptr, w_grant_nxt;
  logic [31:0]         r_lfsr;
  logic [IDX_W:0]      r_cnt;

  logic                w_free_any, w_tail_hit, w_pick_any;
  logic [IDX_W-1:0]    w_free_idx, w_tail_idx, w_pick_idx, w_base;
  logic [OSTD_NUM-1:0] w_elig;
  logic                w_accept, w_hs, w_last, w_retire;

  assign w_elig       = r_vld & ~r_dep_vld;
  assign out_rvalid   = (r_state == S_BURST);
  assign w_last       = (r_beat[r_grant] == r_len[r_grant]);
  assign out_rlast    = out_rvalid && w_last;
  assign out_rid      = out_rvalid ? r_id[r_grant] : '0;
  assign out_rdata    = r_lfsr[AXI_DATA_W-1:0];
  assign out_rresp    = '0;
  assign out_arready  = !srst && w_free_any;
  assign out_ostd_cnt = r_cnt;
  assign w_hs         = out_rvalid && in_rready;
  assign w_retire     = w_hs && w_last;
  assign w_accept     = in_arvalid && out_arready;

  always_comb begin
    logic [IDX_W-1:0] cand;
    w_free_any = 1'b0;
    w_free_idx = '0;
    w_tail_hit = 1'b0;
    w_tail_idx = '0;
    w_pick_any = 1'b0;
    w_pick_idx = '0;
    cand       = '0;
    w_base     = (r_state == S_IDLE) ? r_rr_ptr : r_grant + 1'b1;
    for (int unsigned i = 0; i < OSTD_NUM; i++) begin
      if (!r_vld[i] && !w_free_any) begin
        w_free_any = 1'b1;
        w_free_idx = IDX_W'(i);
      end
      // A tail retiring this cycle needs no successor link: its burst is already done.
      if (r_vld[i] && r_tail[i] && (r_id[i] == in_arid) &&
          !(w_retire && (r_grant == IDX_W'(i)))) begin
        w_tail_hit = 1'b1;
        w_tail_idx = IDX_W'(i);
      end
    end
    for (int unsigned k = 0; k < OSTD_NUM; k++) begin
      cand = w_base + IDX_W'(k);
      if (!w_pick_any && w_elig[cand] && !((r_state == S_BURST) && (cand == r_grant))) begin
        w_pick_any = 1'b1;
        w_pick_idx = cand;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    case (r_state)
      S_IDLE: begin
        if (w_pick_any) begin
          w_state_nxt = S_BURST;
          w_grant_nxt = w_pick_idx;
        end
      end
      S_BURST: begin
        if (w_hs) begin
          if (w_last)
            w_state_nxt = S_IDLE;
          else if (INTERLEAVE && w_pick_any)
            w_grant_nxt = w_pick_idx;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_lfsr   <= LFSR_SEED;
      r_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      if (w_hs)
        r_lfsr <= {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_TAPS : '0);
      if (w_retire)
        r_rr_ptr <= r_grant + 1'b1;
      case ({w_accept, w_retire})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      r_vld     <= '0;
      r_tail    <= '0;
      r_dep_vld <= '0;
    end else begin
      for (int unsigned i = 0; i < OSTD_NUM; i++) begin
        if (w_retire && r_dep_vld[i] && (r_dep_idx[i] == r_grant))
          r_dep_vld[i] <= 1'b0;
      end
      if (w_hs && !w_last)
        r_beat[r_grant] <= r_beat[r_grant] + 4'd1;
      if (w_retire)
        r_vld[r_grant] <= 1'b0;
      if (w_accept) begin
        r_vld[w_free_idx]     <= 1'b1;
        r_id[w_free_idx]      <= in_arid;
        r_len[w_free_idx]     <= in_arlen;
        r_beat[w_free_idx]    <= '0;
        r_tail[w_free_idx]    <= 1'b1;
        r_dep_vld[w_free_idx] <= w_tail_hit;
        r_dep_idx[w_free_idx] <= w_tail_idx;
        if (w_tail_hit)
          r_tail[w_tail_idx] <= 1'b0;
      end
    end
  end

endmodule
